// File: rtl/fp_normalize_pipe_pkg.sv
// Shared format definitions for the floating-point adder datapath.
// Each format selector maps to exponent, stored-mantissa and protect-bit widths.
package fp_normalize_pipe_pkg;

    localparam int FP32 = 0;
    localparam int FP16 = 1;
    localparam int BF16 = 2;

    // Guard, round and sticky bits carried below the mantissa in every format.
    localparam int PROTECT_LEN = 3;

    function automatic int getExpLen(input int fmt);
        case (fmt)
            FP16:    return 5;
            BF16:    return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int getMantissaLen(input int fmt);
        case (fmt)
            FP16:    return 10;
            BF16:    return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int getProtectLen(input int fmt);
        case (fmt)
            default: return PROTECT_LEN;
        endcase
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Tree-structured leading-zero counter. The input is padded on the LSB side
// with ones up to a power of two, so an all-zero input naturally counts WIDTH.
module fp_lzc #(
    parameter  int WIDTH = 27,
    localparam int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [OUT_W-1:0] count_o
);

    localparam int LVLS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int N    = 1 << LVLS;

    logic [N-1:0]                      padded;
    logic [LVLS:0][N-1:0]              nodeValid;
    logic [LVLS:0][N-1:0][LVLS-1:0]    nodeCount;

    // Pairwise reduction: each node keeps "any one below me" and the zero
    // count of its upper half, falling back to the lower half plus its size.
    always_comb begin
        padded                 = '1;
        padded[N-1 -: WIDTH]   = value_i;
        nodeValid              = '0;
        nodeCount              = '0;
        nodeValid[0]           = padded;
        for (int lvl = 1; lvl <= LVLS; lvl++) begin
            for (int n = 0; n < (N >> lvl); n++) begin
                if (nodeValid[lvl-1][2*n+1]) begin
                    nodeValid[lvl][n] = 1'b1;
                    nodeCount[lvl][n] = nodeCount[lvl-1][2*n+1];
                end else begin
                    nodeValid[lvl][n] = nodeValid[lvl-1][2*n];
                    nodeCount[lvl][n] = nodeCount[lvl-1][2*n] + LVLS'(1 << (lvl - 1));
                end
            end
        end
    end

    assign count_o = nodeValid[LVLS][0] ? OUT_W'(nodeCount[LVLS][0]) : OUT_W'(WIDTH);

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage normalisation of the raw mantissa sum after add/sub.
// Stage 1 captures the sum and its leading-zero count; stage 2 shifts the
// mantissa right on carry or left on cancellation, saturates exponent
// overflow to infinity and denormalises results that fall below exponent 1.
module fp_normalize_pipe
    import fp_normalize_pipe_pkg::*;
#(
    parameter  int DATA_FORMAT = FP32,
    parameter  int TAG_W       = 4,
    localparam int E           = getExpLen(DATA_FORMAT),
    localparam int M           = getMantissaLen(DATA_FORMAT),
    localparam int P           = getProtectLen(DATA_FORMAT),
    localparam int W           = M + P + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [E-1:0]     in_exp,
    input  logic [W:0]       in_sum,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_mant,
    output logic [E-1:0]     out_exp,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_tiny,
    output logic             out_zero
);

    localparam int LZ_W = $clog2(W + 1);
    // Exponent math runs one bit wider than either operand so nothing wraps.
    localparam int CW   = ((E > LZ_W) ? E : LZ_W) + 1;
    localparam logic [CW-1:0] EXP_ALL_ONES = CW'((1 << E) - 1);

    logic             adv1;
    logic             adv2;
    logic [LZ_W-1:0]  lzcCount;

    logic             s1Valid_q;
    logic [W:0]       s1Sum_q;
    logic [E-1:0]     s1Exp_q;
    logic [TAG_W-1:0] s1Tag_q;
    logic             s1Carry_q;
    logic             s1Zero_q;
    logic [LZ_W-1:0]  s1Lzc_q;

    logic             s2Valid_q;
    logic [W-1:0]     s2Mant_q;
    logic [E-1:0]     s2Exp_q;
    logic [TAG_W-1:0] s2Tag_q;
    logic             s2Ovf_q;
    logic             s2Tiny_q;
    logic             s2Zero_q;

    logic [W-1:0]     mant_d;
    logic [E-1:0]     exp_d;
    logic             ovf_d;
    logic             tiny_d;
    logic             zero_d;
    logic [CW-1:0]    expWide;
    logic [CW-1:0]    expInc;
    logic [CW-1:0]    lzcWide;

    // A stage may advance when it is empty or its successor is advancing;
    // flush refuses new input so nothing slips in behind the drop.
    assign adv2     = !s2Valid_q || out_ready;
    assign adv1     = !s1Valid_q || adv2;
    assign in_ready = adv1 && !flush;

    fp_lzc #(.WIDTH(W)) uLzc (
        .value_i (in_sum[W-1:0]),
        .count_o (lzcCount)
    );

    // Stage 1 captures the accepted sum with its carry, zero and lzc summary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Sum_q   <= '0;
            s1Exp_q   <= '0;
            s1Tag_q   <= '0;
            s1Carry_q <= 1'b0;
            s1Zero_q  <= 1'b0;
            s1Lzc_q   <= '0;
        end else begin
            if (flush) begin
                s1Valid_q <= 1'b0;
            end else if (adv1) begin
                s1Valid_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1Sum_q   <= in_sum;
                s1Exp_q   <= in_exp;
                s1Tag_q   <= in_tag;
                s1Carry_q <= in_sum[W];
                s1Zero_q  <= (in_sum == '0);
                s1Lzc_q   <= lzcCount;
            end
        end
    end

    // Stage 2 normalise: zero, then carry/overflow, then left shift limited
    // by the exponent so the result never goes below the subnormal encoding.
    always_comb begin
        mant_d  = '0;
        exp_d   = '0;
        ovf_d   = 1'b0;
        tiny_d  = 1'b0;
        zero_d  = 1'b0;
        expWide = CW'(s1Exp_q);
        expInc  = expWide + CW'(1);
        lzcWide = CW'(s1Lzc_q);
        if (s1Zero_q) begin
            zero_d = 1'b1;
        end else if (s1Carry_q) begin
            if (expInc >= EXP_ALL_ONES) begin
                ovf_d = 1'b1;
                exp_d = '1;
            end else begin
                mant_d = s1Sum_q[W:1] | W'(s1Sum_q[0]);
                exp_d  = expInc[E-1:0];
            end
        end else if (lzcWide + CW'(1) <= expWide) begin
            mant_d = s1Sum_q[W-1:0] << lzcWide;
            exp_d  = E'(expWide - lzcWide);
        end else begin
            mant_d = s1Sum_q[W-1:0] << (expWide - CW'(1));
            tiny_d = 1'b1;
        end
    end

    // Stage 2 is the output register; it holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid_q <= 1'b0;
            s2Mant_q  <= '0;
            s2Exp_q   <= '0;
            s2Tag_q   <= '0;
            s2Ovf_q   <= 1'b0;
            s2Tiny_q  <= 1'b0;
            s2Zero_q  <= 1'b0;
        end else begin
            if (flush) begin
                s2Valid_q <= 1'b0;
            end else if (adv2) begin
                s2Valid_q <= s1Valid_q;
            end
            if (!flush && adv2 && s1Valid_q) begin
                s2Mant_q <= mant_d;
                s2Exp_q  <= exp_d;
                s2Tag_q  <= s1Tag_q;
                s2Ovf_q  <= ovf_d;
                s2Tiny_q <= tiny_d;
                s2Zero_q <= zero_d;
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign out_mant  = s2Mant_q;
    assign out_exp   = s2Exp_q;
    assign out_tag   = s2Tag_q;
    assign out_ovf   = s2Ovf_q;
    assign out_tiny  = s2Tiny_q;
    assign out_zero  = s2Zero_q;

endmodule
